resc_stoch_to_bin: RTL and testbench

RESC_STOCH_TO_BIN -- requirements
Module: resc_stoch_to_bin

---
 rtl/resc_stoch_to_bin.sv | 77 +++++++
 tb/tb_resc_stoch_to_bin.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/resc_stoch_to_bin.sv
// Stochastic bitstream to binary converter: counts ones over 2^WIDTH valid samples.
// Latency 2^WIDTH valid cycles + 1; bit_valid gaps stretch the conversion; start is ignored while counting.
module resc_stoch_to_bin #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] y_bin,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SAMPLE_ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] samples;
    logic [WIDTH:0]   ones;
    logic [WIDTH:0]   ones_inc;
    logic             last_sample;

    assign ones_inc    = ones + {{WIDTH{1'b0}}, bit_in};
    assign last_sample = (state == COUNT) && bit_valid && (samples == {WIDTH{1'b1}});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COUNT;
            COUNT:   if (last_sample) state_nxt = DONE;
            DONE:    state_nxt = start ? COUNT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samples <= '0;
            ones    <= '0;
        end else if (state != COUNT && start) begin
            samples <= '0;
            ones    <= '0;
        end else if (state == COUNT && bit_valid) begin
            samples <= samples + SAMPLE_ONE;
            ones    <= ones_inc;
        end
    end

    // The final sample is folded in here; an all-ones stream saturates to the top code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_bin <= '0;
        end else if (last_sample) begin
            y_bin <= ones_inc[WIDTH] ? {WIDTH{1'b1}} : ones_inc[WIDTH-1:0];
        end
    end

    assign done = (state == DONE);
    assign busy = (state == COUNT);

endmodule

// File: tb/tb_resc_stoch_to_bin.sv
// Self-checking bench for resc_stoch_to_bin with WIDTH=10, against a sum-and-saturate reference.
module tb_resc_stoch_to_bin;

    localparam int W    = 10;
    localparam int NS   = 1 << W;
    localparam int MAXV = NS - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         bit_in;
    logic         bit_valid;
    logic [W-1:0] y_bin;
    logic         done;
    logic         busy;

    int errs   = 0;
    int checks = 0;
    bit pat [NS];

    resc_stoch_to_bin #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .y_bin    (y_bin),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: number of ones in the stream, clipped to the top code.
    function automatic int model_result();
        int s = 0;
        for (int i = 0; i < NS; i++) s += int'(pat[i]);
        return (s > MAXV) ? MAXV : s;
    endfunction

    task automatic shuffle_pat();
        for (int i = 0; i < NS; i++) begin
            int j;
            bit t;
            j      = $urandom_range(NS - 1);
            t      = pat[i];
            pat[i] = pat[j];
            pat[j] = t;
        end
    endtask

    task automatic begin_conv();
        start     = 1'b1;
        bit_valid = 1'($urandom_range(1));
        bit_in    = 1'($urandom_range(1));
        cycle();
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    // gap_mode: 0 none, 1 every third cycle invalid, 2 random; start_mode: 0 low, 1 random, 2 high
    task automatic drive_conv(input int gap_mode, input int start_mode,
                              output int edges, output int gaps, output int glitches);
        int  idx = 0;
        bit  v;
        edges    = 0;
        gaps     = 0;
        glitches = 0;
        while (idx < NS && edges < 10000) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (edges % 3) != 2;
                default: v = $urandom_range(3) != 0;
            endcase
            bit_valid = v;
            bit_in    = v ? pat[idx] : 1'($urandom_range(1));
            start     = (start_mode == 2) ? 1'b1 :
                        (start_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
            cycle();
            edges++;
            if (v) idx++;
            else gaps++;
            if (idx < NS && (done || !busy)) glitches++;
        end
        bit_valid = 1'b0;
        if (start_mode != 2) start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        cycle();
        cycle();
        checks++; if (y_bin !== '0) begin errs++; $display("FAIL reset_y got=%0d want=0", y_bin); end
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b0;
        cycle();
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_all_ones();
        int e, g, gl, exp;
        for (int i = 0; i < NS; i++) pat[i] = 1'b1;
        exp = model_result();
        begin_conv();
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL ones_busy got=%b want=1", busy); end
        drive_conv(0, 0, e, g, gl);
        checks++; if (gl !== 0) begin errs++; $display("FAIL ones_early got=%0d want=0", gl); end
        checks++; if (done !== 1'b1) begin errs++; $display("FAIL ones_done got=%b want=1", done); end
        checks++; if (y_bin !== W'(exp)) begin errs++; $display("FAIL ones_y got=%0d want=%0d", y_bin, exp); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL ones_busy_done got=%b want=0", busy); end
        cycle();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL ones_after got=%b%b want=00", done, busy); end
        checks++; if (y_bin !== W'(MAXV)) begin errs++; $display("FAIL ones_hold got=%0d want=%0d", y_bin, MAXV); end
    endtask

    task automatic test_split();
        int e, g, gl, exp;
        for (int i = 0; i < NS; i++) pat[i] = (i < 549);
        exp = model_result();
        begin_conv();
        checks++; if (y_bin !== W'(MAXV)) begin errs++; $display("FAIL split_hold got=%0d want=%0d", y_bin, MAXV); end
        drive_conv(0, 0, e, g, gl);
        checks++; if (e !== NS || gl !== 0 || done !== 1'b1) begin
            errs++; $display("FAIL split_latency got=edges %0d early %0d done %b want=edges %0d early 0 done 1", e, gl, done, NS);
        end
        checks++; if (y_bin !== W'(exp)) begin errs++; $display("FAIL split_y got=%0d want=%0d", y_bin, exp); end
        cycle();
    endtask

    task automatic test_gaps();
        int e, g, gl, exp, exp_edges;
        for (int i = 0; i < NS; i++) pat[i] = (i % 2 == 0);
        exp       = model_result();
        exp_edges = NS + (NS - 1) / 2;
        begin_conv();
        drive_conv(1, 0, e, g, gl);
        checks++; if (e !== exp_edges || gl !== 0 || done !== 1'b1) begin
            errs++; $display("FAIL gaps_latency got=edges %0d early %0d done %b want=edges %0d early 0 done 1", e, gl, done, exp_edges);
        end
        checks++; if (y_bin !== W'(exp)) begin errs++; $display("FAIL gaps_y got=%0d want=%0d", y_bin, exp); end
        cycle();
    endtask

    task automatic test_random();
        int e, g, gl, exp, thr;
        for (int n = 0; n < 3; n++) begin
            thr = $urandom_range(100);
            for (int i = 0; i < NS; i++) pat[i] = ($urandom_range(99) < thr);
            exp = model_result();
            begin_conv();
            drive_conv(2, 0, e, g, gl);
            checks++; if (gl !== 0 || done !== 1'b1) begin
                errs++; $display("FAIL rand_done got=early %0d done %b want=early 0 done 1", gl, done);
            end
            checks++; if (y_bin !== W'(exp)) begin errs++; $display("FAIL rand_y got=%0d want=%0d", y_bin, exp); end
            cycle();
            checks++; if (done !== 1'b0) begin errs++; $display("FAIL rand_pulse got=%b want=0", done); end
        end
    endtask

    task automatic test_reset_mid();
        int e, g, gl, seen;
        begin_conv();
        for (int i = 0; i < 300; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(1));
            cycle();
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (y_bin !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL mid_reset got=y %0d busy %b done %b want=0 0 0", y_bin, busy, done);
        end
        cycle();
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(1));
            cycle();
            if (done || busy) seen++;
        end
        bit_valid = 1'b0;
        checks++; if (seen !== 0) begin errs++; $display("FAIL mid_idle got=%0d active cycles want=0", seen); end
        for (int i = 0; i < NS; i++) pat[i] = 1'b0;
        begin_conv();
        drive_conv(2, 0, e, g, gl);
        checks++; if (done !== 1'b1 || y_bin !== W'(model_result())) begin
            errs++; $display("FAIL mid_zero got=done %b y %0d want=done 1 y %0d", done, y_bin, model_result());
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int e, g, gl, exp;
        for (int i = 0; i < NS; i++) pat[i] = 1'b1;
        start = 1'b1;
        cycle();
        drive_conv(0, 2, e, g, gl);
        checks++; if (done !== 1'b1 || y_bin !== W'(MAXV)) begin
            errs++; $display("FAIL b2b_first got=done %b y %0d want=done 1 y %0d", done, y_bin, MAXV);
        end
        for (int i = 0; i < NS; i++) pat[i] = (i < 309);
        shuffle_pat();
        exp = model_result();
        cycle();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errs++; $display("FAIL b2b_turn got=busy %b done %b want=busy 1 done 0", busy, done);
        end
        drive_conv(2, 2, e, g, gl);
        checks++; if (gl !== 0 || done !== 1'b1) begin errs++; $display("FAIL b2b_second_done got=early %0d done %b want=0 1", gl, done); end
        checks++; if (y_bin !== W'(exp)) begin errs++; $display("FAIL b2b_second_y got=%0d want=%0d", y_bin, exp); end
        start = 1'b0;
        cycle();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL b2b_idle got=busy %b done %b want=0 0", busy, done); end
    endtask

    task automatic test_restart_ignored();
        int e, g, gl, exp;
        for (int i = 0; i < NS; i++) pat[i] = ($urandom_range(2) == 0);
        exp = model_result();
        begin_conv();
        drive_conv(2, 1, e, g, gl);
        checks++; if (gl !== 0 || done !== 1'b1) begin errs++; $display("FAIL restart_done got=early %0d done %b want=0 1", gl, done); end
        checks++; if (y_bin !== W'(exp)) begin errs++; $display("FAIL restart_y got=%0d want=%0d", y_bin, exp); end
        start = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_split();
        test_gaps();
        test_random();
        test_reset_mid();
        test_back_to_back();
        test_restart_ignored();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
